// File: rtl/bc_solver_pkg.sv
// bc_pkg: shared types and helpers for the bulls-and-cows guessing solver.
//   bc_state_e   - solver FSM states
//   NUM_CAND     - number of two-digit candidates (00..99)
//   LAST_CAND    - highest candidate value
//   bc_hist_t    - one recorded (guess, bulls, cows) response
//   split_digits - binary 0..99 -> {tens[3:0], ones[3:0]}
package bc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEARCH = 3'd1,
    EMIT   = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4,
    FAIL   = 3'd5
  } bc_state_e;

  localparam int         NUM_CAND  = 100;
  localparam logic [7:0] LAST_CAND = 8'(NUM_CAND - 1);

  typedef struct packed {
    logic       valid;
    logic [7:0] guess;
    logic [2:0] bulls;
    logic [2:0] cows;
  } bc_hist_t;

  // Inputs are always 0..99, so the quotient fits in the upper nibble.
  function automatic logic [7:0] split_digits(input logic [7:0] v);
    return ((v / 8'd10) << 4) | (v % 8'd10);
  endfunction

endpackage

// File: rtl/bc_solver_score_ref.sv
// bc_score_ref: combinational bulls/cows scorer for one (secret, guess) pair.
//   secret_i [7:0] - secret as binary 0..99
//   guess_i  [7:0] - guess as binary 0..99
//   bulls_o  [2:0] - bulls 0..2
//   cows_o   [2:0] - cows 0..2
// The checks are a priority chain; order matters for repeated digits.
import bc_pkg::*;

module bc_score_ref (
  input  logic [7:0] secret_i,
  input  logic [7:0] guess_i,
  output logic [2:0] bulls_o,
  output logic [2:0] cows_o
);

  logic [7:0] s_dig;
  logic [7:0] g_dig;
  logic [3:0] s_t, s_o, g_t, g_o;

  assign s_dig = split_digits(secret_i);
  assign g_dig = split_digits(guess_i);
  assign s_t   = s_dig[7:4];
  assign s_o   = s_dig[3:0];
  assign g_t   = g_dig[7:4];
  assign g_o   = g_dig[3:0];

  always_comb begin
    bulls_o = 3'd0;
    cows_o  = 3'd0;
    if (g_t == s_t && g_o == s_o) begin
      bulls_o = 3'd2;
    end else if (g_t == s_t || g_o == s_o) begin
      bulls_o = 3'd1;
    end else if ((g_t == s_o && g_o != s_t) || (g_o == s_t && g_t != s_o)) begin
      cows_o = 3'd1;
    end else if (g_t == s_o && g_o == s_t) begin
      cows_o = 3'd2;
    end
  end

endmodule

// File: rtl/bc_solver.sv
// bc_solver: guessing side of two-digit bulls-and-cows.
// Each guess is the lowest candidate consistent with every recorded response.
//   clk, rst            - clock, asynchronous active-high reset
//   start               - begin a game from IDLE/DONE/FAIL
//   guess, guess_valid  - guess offered; transfer on guess_valid && guess_ready
//   guess_ready         - consumer accepts guess
//   resp_valid          - response strobe, sampled only in WAIT
//   bulls, cows         - response for the last accepted guess
//   busy, done, fail    - status; done/fail held until start or rst
//   solution            - winning guess while done
//   tries               - guesses accepted this game
//   dbg_state           - current FSM state (bc_state_e encoding)
// Handshake: guess_valid stays high with guess stable until a cycle where
// guess_ready is also high; that cycle is the transfer and guess_valid drops
// on the next cycle. resp_valid is a one-cycle strobe honoured only in WAIT.
// Build option: BC_SOLVER_DISTINCT_EN excludes candidates with equal digits.
import bc_pkg::*;

module bc_solver #(
  parameter int MAX_TRIES = 10,
  parameter int TRY_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [7:0]       guess,
  output logic             guess_valid,
  input  logic             guess_ready,
  input  logic             resp_valid,
  input  logic [2:0]       bulls,
  input  logic [2:0]       cows,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [7:0]       solution,
  output logic [TRY_W-1:0] tries,
  output logic [2:0]       dbg_state
);

  bc_state_e        state_q, state_d;
  logic [7:0]       cand_q, guess_q, solution_q;
  logic [TRY_W-1:0] tries_q;
  logic             done_q, fail_q;
  bc_hist_t         hist_q [MAX_TRIES];

  logic [MAX_TRIES-1:0] entry_ok;
  logic                 eligible, consistent;
  logic [7:0]           scan_last;

  // One scorer per history slot: the candidate plays the secret.
  for (genvar i = 0; i < MAX_TRIES; i++) begin : g_chk
    logic [2:0] sb, sc;
    bc_score_ref u_score (
      .secret_i (cand_q),
      .guess_i  (hist_q[i].guess),
      .bulls_o  (sb),
      .cows_o   (sc)
    );
    assign entry_ok[i] = !hist_q[i].valid ||
                         (sb == hist_q[i].bulls && sc == hist_q[i].cows);
  end

`ifdef BC_SOLVER_DISTINCT_EN
  logic [7:0] cand_dig;
  assign cand_dig  = split_digits(cand_q);
  assign eligible  = (cand_dig[7:4] != cand_dig[3:0]);
  // 99 can never be eligible, so the scan ends one earlier.
  assign scan_last = LAST_CAND - 8'd1;
`else
  assign eligible  = 1'b1;
  assign scan_last = LAST_CAND;
`endif

  assign consistent = eligible && (&entry_ok);

  logic start_ok, resp_win, at_limit, cand_end, guess_end;
  assign start_ok  = start && (state_q == IDLE || state_q == DONE || state_q == FAIL);
  assign resp_win  = (bulls == 3'd2);
  assign at_limit  = (tries_q == TRY_W'(MAX_TRIES));
  assign cand_end  = (cand_q == scan_last);
  assign guess_end = (guess_q == scan_last);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, FAIL: if (start_ok) state_d = SEARCH;
      SEARCH: begin
        if (consistent)    state_d = EMIT;
        else if (cand_end) state_d = FAIL;
      end
      EMIT: if (guess_ready) state_d = WAIT;
      WAIT: begin
        if (resp_valid) begin
          if (resp_win)                   state_d = DONE;
          else if (at_limit || guess_end) state_d = FAIL;
          else                            state_d = SEARCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy        = (state_q == SEARCH) || (state_q == EMIT) || (state_q == WAIT);
    guess_valid = (state_q == EMIT);
    dbg_state   = state_q;
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q     <= 8'd0;
      guess_q    <= 8'd0;
      solution_q <= 8'd0;
      tries_q    <= '0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      for (int i = 0; i < MAX_TRIES; i++) hist_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE, DONE, FAIL: begin
          if (start_ok) begin
            cand_q     <= 8'd0;
            tries_q    <= '0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            solution_q <= 8'd0;
            for (int i = 0; i < MAX_TRIES; i++) hist_q[i] <= '0;
          end
        end
        SEARCH: begin
          if (consistent)    guess_q <= cand_q;
          else if (cand_end) fail_q  <= 1'b1;
          else               cand_q  <= cand_q + 8'd1;
        end
        EMIT: if (guess_ready) tries_q <= tries_q + 1'b1;
        WAIT: begin
          if (resp_valid) begin
            // tries already counts this guess, so its slot is tries-1.
            for (int i = 0; i < MAX_TRIES; i++) begin
              if (TRY_W'(i) == tries_q - 1'b1)
                hist_q[i] <= '{valid: 1'b1, guess: guess_q, bulls: bulls, cows: cows};
            end
            if (resp_win) begin
              done_q     <= 1'b1;
              solution_q <= guess_q;
            end else if (at_limit || guess_end) begin
              fail_q <= 1'b1;
            end else begin
              // Everything at or below the last guess is already eliminated.
              cand_q <= guess_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign guess    = guess_q;
  assign done     = done_q;
  assign fail     = fail_q;
  assign solution = solution_q;
  assign tries    = tries_q;

endmodule

// File: tb/tb_bc_solver.sv
module tb_bc_solver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       guess_ready = 1'b0;
  logic       resp_valid = 1'b0;
  logic [2:0] bulls = 3'd0;
  logic [2:0] cows = 3'd0;

  logic [7:0] guess, solution;
  logic       guess_valid, busy, done, fail;
  logic [3:0] tries;
  logic [2:0] dbg_state;

  logic [7:0] guess16, solution16;
  logic       guess_valid16, busy16, done16, fail16;
  logic [4:0] tries16;
  logic [2:0] dbg_state16;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  bc_solver dut (
    .clk(clk), .rst(rst), .start(start),
    .guess(guess), .guess_valid(guess_valid), .guess_ready(guess_ready),
    .resp_valid(resp_valid), .bulls(bulls), .cows(cows),
    .busy(busy), .done(done), .fail(fail), .solution(solution),
    .tries(tries), .dbg_state(dbg_state)
  );

  // Larger history: shares all inputs with dut, so it follows the same game.
  bc_solver #(.MAX_TRIES(16), .TRY_W(5)) dut16 (
    .clk(clk), .rst(rst), .start(start),
    .guess(guess16), .guess_valid(guess_valid16), .guess_ready(guess_ready),
    .resp_valid(resp_valid), .bulls(bulls), .cows(cows),
    .busy(busy16), .done(done16), .fail(fail16), .solution(solution16),
    .tries(tries16), .dbg_state(dbg_state16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference scoring rule, priority order as in the game definition.
  function automatic logic [5:0] ref_score(input logic [7:0] s, input logic [7:0] g);
    int a, b, sa, sb;
    sa = int'(s) / 10; sb = int'(s) % 10;
    a  = int'(g) / 10; b  = int'(g) % 10;
    if (a == sa && b == sb)                              return {3'd2, 3'd0};
    if (a == sa || b == sb)                              return {3'd1, 3'd0};
    if ((a == sb && b != sa) || (b == sa && a != sb))    return {3'd0, 3'd1};
    if (a == sb && b == sa)                              return {3'd0, 3'd2};
    return 6'd0;
  endfunction

  // Driver + responder. Each accepted guess is popped from exp_q and compared.
  // stop_tries > 0 returns while in WAIT right after that many acceptances.
  task automatic run_game(input logic [7:0] secret, input bit zero_mode,
                          input int stop_tries, output int first_gv,
                          output bit timed_out);
    bit         need_resp;
    logic [7:0] g_acc, e;
    need_resp = 1'b0;
    first_gv  = -1;
    timed_out = 1'b1;
    g_acc     = 8'd0;
    @(negedge clk); start = 1'b1; guess_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      resp_valid = 1'b0;
      if (done || fail) begin timed_out = 1'b0; break; end
      if (stop_tries > 0 && need_resp && int'(tries) == stop_tries) begin
        timed_out = 1'b0; break;
      end
      if (guess_valid) begin
        if (first_gv < 0) first_gv = cyc;
        g_acc = guess;
        if (exp_q.size() == 0) chk("extra_guess", 32'(g_acc), 32'hFF);
        else begin
          e = exp_q.pop_front();
          chk("guess_order", 32'(g_acc), 32'(e));
        end
        need_resp = 1'b1;
      end else if (need_resp) begin
        resp_valid = 1'b1;
        if (zero_mode) {bulls, cows} = 6'd0;
        else           {bulls, cows} = ref_score(secret, g_acc);
        need_resp = 1'b0;
      end
    end
  endtask

  typedef struct {
    logic [7:0] secret;
    bit         zero_resp;
    int         n_g;
    int         g[10];
    bit         exp_done;
    bit         exp_fail;
    logic [7:0] exp_sol;
    int         exp_tries;
  } vec_t;

  vec_t v[5];
  int   first_gv;
  bit   to;
  bit   got;

  initial begin
    v[0] = '{8'd0,  1'b0, 1,  '{0,0,0,0,0,0,0,0,0,0},            1'b1, 1'b0, 8'd0,  1};
    v[1] = '{8'd37, 1'b0, 8,  '{0,11,22,33,34,35,36,37,0,0},     1'b1, 1'b0, 8'd37, 8};
    v[2] = '{8'd99, 1'b0, 10, '{0,11,22,33,44,55,66,77,88,99},   1'b1, 1'b0, 8'd99, 10};
    v[3] = '{8'd50, 1'b1, 10, '{0,11,22,33,44,55,66,77,88,99},   1'b0, 1'b1, 8'd0,  10};
    v[4] = '{8'd52, 1'b0, 6,  '{0,11,22,23,42,52,0,0,0,0},       1'b1, 1'b0, 8'd52, 6};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_guess", 32'(guess), 0);
    chk("rst_guess_valid", 32'(guess_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_fail", 32'(fail), 0);
    chk("rst_solution", 32'(solution), 0);
    chk("rst_tries", 32'(tries), 0);
    rst = 1'b0;

    // table-driven games
    for (int t = 0; t < 5; t++) begin
      exp_q.delete();
      for (int i = 0; i < v[t].n_g; i++) exp_q.push_back(8'(v[t].g[i]));
      run_game(v[t].secret, v[t].zero_resp, 0, first_gv, to);
      chk($sformatf("v%0d_timeout", t), 32'(to), 0);
      // start driven, one cycle in SEARCH, then guess_valid: seen on loop cycle 1
      chk($sformatf("v%0d_first_guess_latency", t), 32'(first_gv), 1);
      chk($sformatf("v%0d_done", t), 32'(done), 32'(v[t].exp_done));
      chk($sformatf("v%0d_fail", t), 32'(fail), 32'(v[t].exp_fail));
      chk($sformatf("v%0d_solution", t), 32'(solution), 32'(v[t].exp_sol));
      chk($sformatf("v%0d_tries", t), 32'(tries), 32'(v[t].exp_tries));
      chk($sformatf("v%0d_guesses_left", t), 32'(exp_q.size()), 0);
      chk($sformatf("v%0d_busy", t), 32'(busy), 0);
      if (v[t].zero_resp) begin
        chk("m16_fail", 32'(fail16), 1);
        chk("m16_done", 32'(done16), 0);
        chk("m16_tries", 32'(tries16), 10);
      end
    end

    // guess_ready stalled in EMIT; resp_valid and start there are ignored
    @(negedge clk); start = 1'b1; guess_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (guess_valid) begin got = 1'b1; break; end
    end
    chk("stall_reach_emit", 32'(got), 1);
    for (int k = 0; k < 5; k++) begin
      chk("stall_guess_valid", 32'(guess_valid), 1);
      chk("stall_guess", 32'(guess), 0);
      chk("stall_tries", 32'(tries), 0);
      resp_valid = (k == 1);
      bulls      = 3'd2;
      cows       = 3'd0;
      start      = (k == 2);
      @(negedge clk);
    end
    resp_valid = 1'b0;
    start      = 1'b0;
    chk("stall_still_valid", 32'(guess_valid), 1);
    chk("stall_done_ignored", 32'(done), 0);
    chk("stall_tries_held", 32'(tries), 0);
    guess_ready = 1'b1;
    @(negedge clk);
    chk("accept_valid_drop", 32'(guess_valid), 0);
    chk("accept_tries", 32'(tries), 1);
    chk("accept_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // asynchronous reset in WAIT after three tries, then replay
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(8'(v[1].g[i]));
    run_game(8'd37, 1'b0, 3, first_gv, to);
    chk("rstwait_timeout", 32'(to), 0);
    chk("rstwait_tries", 32'(tries), 3);
    chk("rstwait_busy", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_guess", 32'(guess), 0);
    chk("async_guess_valid", 32'(guess_valid), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_done", 32'(done), 0);
    chk("async_fail", 32'(fail), 0);
    chk("async_solution", 32'(solution), 0);
    chk("async_tries", 32'(tries), 0);
    @(negedge clk); rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < v[1].n_g; i++) exp_q.push_back(8'(v[1].g[i]));
    run_game(8'd37, 1'b0, 0, first_gv, to);
    chk("replay_timeout", 32'(to), 0);
    chk("replay_done", 32'(done), 1);
    chk("replay_solution", 32'(solution), 37);
    chk("replay_tries", 32'(tries), 8);
    chk("replay_guesses_left", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
